// File: rtl/register_scoreboard_pkg.sv
// ============================================================================
// Module   : core_pkg
// Purpose  : Shared types, sizes and helpers for the register scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package core_pkg;

    localparam int NREG = 8;
    localparam int RW   = 3;

    typedef enum logic [2:0] {
        NONE        = 3'd0,
        STALL       = 3'd1,
        FWD_PENDING = 3'd2,
        WB_BYPASS   = 3'd3
    } reg_status_t;

    typedef struct packed {
        logic          valid;
        logic [RW-1:0] rd;
        logic          is_load;
        logic          data_ready;
    } sb_tag_t;

    localparam logic [1:0] c_STG_EX  = 2'd0;
    localparam logic [1:0] c_STG_MEM = 2'd1;
    localparam logic [1:0] c_STG_WB  = 2'd2;

    // Status a stage contributes when its tag matches the register being decoded.
    function automatic reg_status_t stage_code(input sb_tag_t t, input logic [1:0] stg,
                                               input logic load_done);
        reg_status_t c;
        c = NONE;
        case (stg)
            c_STG_EX:  c = t.is_load ? STALL : FWD_PENDING;
            c_STG_MEM: c = (t.data_ready || (load_done && t.is_load)) ? FWD_PENDING : STALL;
            default:   c = t.valid ? WB_BYPASS : NONE;
        endcase
        return c;
    endfunction

    function automatic logic [1:0] count_valid(input logic a, input logic b, input logic c);
        return {(a & b) | (a & c) | (b & c), a ^ b ^ c};
    endfunction

endpackage

`default_nettype wire

// File: rtl/register_scoreboard_if.sv
// ============================================================================
// Module   : register_scoreboard_if
// Purpose  : Pipeline-control inputs and status outputs of the scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface register_scoreboard_if;
    import core_pkg::*;

    logic          id_wr_en;
    logic [RW-1:0] id_rd;
    logic          id_is_load;
    logic          en_idex;
    logic          flush_idex;
    logic          en_exmem;
    logic          flush_exmem;
    logic          en_memwb;
    logic          flush_memwb;
    logic          mem_load_done;
    logic [2:0]    register_invalid [NREG-1:0];
    logic [1:0]    pending_count;

    modport master (
        output id_wr_en, id_rd, id_is_load,
        output en_idex, flush_idex, en_exmem, flush_exmem, en_memwb, flush_memwb,
        output mem_load_done,
        input  register_invalid, pending_count
    );

    modport slave (
        input  id_wr_en, id_rd, id_is_load,
        input  en_idex, flush_idex, en_exmem, flush_exmem, en_memwb, flush_memwb,
        input  mem_load_done,
        output register_invalid, pending_count
    );

endinterface

`default_nettype wire

// File: rtl/register_scoreboard_slot.sv
// ============================================================================
// Module   : sb_stage_slot
// Purpose  : One pipeline-stage destination tag with flush/enable/ready-set.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sb_stage_slot
    import core_pkg::*;
(
    input  wire logic    clk,
    input  wire logic    reset_n,
    input  wire logic    i_en,
    input  wire logic    i_flush,
    input  wire logic    i_ready_set,
    input  wire sb_tag_t i_load,
    output sb_tag_t      o_tag,
    output logic         o_next_valid
);

    sb_tag_t r_tag;
    sb_tag_t w_next;

    always_comb begin
        w_next = r_tag;
        if (i_flush) begin
            w_next = '0;
        end else if (i_en) begin
            w_next = i_load;
        end else if (i_ready_set && r_tag.valid && r_tag.is_load) begin
            w_next.data_ready = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_tag <= '0;
        end else begin
            r_tag <= w_next;
        end
    end

    assign o_tag        = r_tag;
    assign o_next_valid = w_next.valid;

endmodule

`default_nettype wire

// File: rtl/register_scoreboard.sv
// ============================================================================
// Module   : register_scoreboard
// Purpose  : EX/MEM/WB destination tracking and per-register hazard status.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module register_scoreboard
    import core_pkg::*;
(
    input  wire logic             clk,
    input  wire logic             reset_n,
    register_scoreboard_if.slave  sb
);

    sb_tag_t    w_ex_load;
    sb_tag_t    w_mem_load;
    sb_tag_t    w_ex;
    sb_tag_t    w_mem;
    sb_tag_t    w_wb;
    logic       w_ex_nv;
    logic       w_mem_nv;
    logic       w_wb_nv;
    logic [2:0] w_status [NREG-1:0];
    logic [1:0] r_pending;

    always_comb begin
        w_ex_load            = '0;
        w_ex_load.valid      = sb.id_wr_en;
        w_ex_load.rd         = sb.id_rd;
        w_ex_load.is_load    = sb.id_is_load;
        // ALU results are ready for forwarding as soon as they leave EX.
        w_mem_load            = w_ex;
        w_mem_load.data_ready = ~w_ex.is_load;
    end

    sb_stage_slot u_ex (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_en         (sb.en_idex),
        .i_flush      (sb.flush_idex),
        .i_ready_set  (1'b0),
        .i_load       (w_ex_load),
        .o_tag        (w_ex),
        .o_next_valid (w_ex_nv)
    );

    sb_stage_slot u_mem (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_en         (sb.en_exmem),
        .i_flush      (sb.flush_exmem),
        .i_ready_set  (sb.mem_load_done),
        .i_load       (w_mem_load),
        .o_tag        (w_mem),
        .o_next_valid (w_mem_nv)
    );

    sb_stage_slot u_wb (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_en         (sb.en_memwb),
        .i_flush      (sb.flush_memwb),
        .i_ready_set  (1'b0),
        .i_load       (w_mem),
        .o_tag        (w_wb),
        .o_next_valid (w_wb_nv)
    );

    // Youngest matching stage wins: EX, then MEM, then WB.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            w_status[r] = NONE;
            if (w_ex.valid && (w_ex.rd == RW'(r))) begin
                w_status[r] = stage_code(w_ex, c_STG_EX, 1'b0);
            end else if (w_mem.valid && (w_mem.rd == RW'(r))) begin
                w_status[r] = stage_code(w_mem, c_STG_MEM, sb.mem_load_done);
            end else if (w_wb.valid && (w_wb.rd == RW'(r))) begin
                w_status[r] = stage_code(w_wb, c_STG_WB, 1'b0);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_pending <= 2'd0;
        end else begin
            r_pending <= count_valid(w_ex_nv, w_mem_nv, w_wb_nv);
        end
    end

    assign sb.register_invalid = w_status;
    assign sb.pending_count    = r_pending;

endmodule

`default_nettype wire

// File: tb/tb_register_scoreboard.sv
// ============================================================================
// Module   : tb_register_scoreboard
// Purpose  : Self-checking bench for register_scoreboard against a pipeline model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_register_scoreboard;
    import core_pkg::*;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    register_scoreboard_if sbif ();

    register_scoreboard dut (
        .clk     (clk),
        .reset_n (reset_n),
        .sb      (sbif)
    );

    typedef struct {
        bit v;
        int rd;
        bit ld;
        bit rdy;
    } instr_t;

    instr_t pipe [3];   // 0 = EX, 1 = MEM, 2 = WB
    int     m_pending;
    int     n_checks;
    int     n_fail;

    function automatic int exp_code(int r);
        for (int s = 0; s < 3; s++) begin
            if (pipe[s].v && pipe[s].rd == r) begin
                if (s == 0) return pipe[s].ld ? 1 : 2;
                if (s == 1) return (pipe[s].rdy || (sbif.mem_load_done && pipe[s].ld)) ? 2 : 1;
                return 3;
            end
        end
        return 0;
    endfunction

    task automatic drive(bit wr, int rd, bit ld, bit ei, bit fi, bit ex, bit fx,
                         bit ew, bit fw, bit done);
        sbif.id_wr_en      = wr;
        sbif.id_rd         = RW'(rd);
        sbif.id_is_load    = ld;
        sbif.en_idex       = ei;
        sbif.flush_idex    = fi;
        sbif.en_exmem      = ex;
        sbif.flush_exmem   = fx;
        sbif.en_memwb      = ew;
        sbif.flush_memwb   = fw;
        sbif.mem_load_done = done;
    endtask

    // Advance one clock and move instructions through the model pipeline.
    task automatic tick();
        instr_t o [3];
        instr_t e;
        @(posedge clk);
        o = pipe;
        e = '{0, 0, 0, 0};
        if (!reset_n) begin
            pipe = '{e, e, e};
        end else begin
            pipe[2] = sbif.flush_memwb ? e : (sbif.en_memwb ? o[1] : o[2]);
            if (sbif.flush_exmem) pipe[1] = e;
            else if (sbif.en_exmem) pipe[1] = '{o[0].v, o[0].rd, o[0].ld, !o[0].ld};
            else begin
                pipe[1] = o[1];
                if (sbif.mem_load_done && o[1].v && o[1].ld) pipe[1].rdy = 1;
            end
            if (sbif.flush_idex) pipe[0] = e;
            else if (sbif.en_idex) pipe[0] = '{sbif.id_wr_en, int'(sbif.id_rd), sbif.id_is_load, 0};
        end
        m_pending = int'(pipe[0].v) + int'(pipe[1].v) + int'(pipe[2].v);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        drive(1, 3, 0, 1, 0, 1, 0, 1, 0, 0);
        tick();
        tick();
        for (int r = 0; r < NREG; r++) begin
            n_checks++;
            if (sbif.register_invalid[r] !== 3'd0) begin
                n_fail++;
                $display("FAIL reset r%0d status got %0d expected 0", r, sbif.register_invalid[r]);
            end
        end
        n_checks++;
        if (sbif.pending_count !== 2'd0) begin
            n_fail++;
            $display("FAIL reset pending got %0d expected 0", sbif.pending_count);
        end
        reset_n = 1'b1;
        drive(0, 0, 0, 1, 0, 1, 0, 1, 0, 0);
        tick();
    endtask

    task automatic test_alu_flow();
        int e3 [4] = '{2, 2, 3, 0};
        int ep [4] = '{1, 1, 1, 0};
        for (int c = 0; c < 4; c++) begin
            drive(c == 0, 3, 0, 1, 0, 1, 0, 1, 0, 0);
            tick();
            n_checks++;
            if (sbif.register_invalid[3] !== 3'(e3[c])) begin
                n_fail++;
                $display("FAIL alu_flow c%0d r3 got %0d expected %0d", c, sbif.register_invalid[3], e3[c]);
            end
            n_checks++;
            if (sbif.pending_count !== 2'(ep[c])) begin
                n_fail++;
                $display("FAIL alu_flow c%0d pending got %0d expected %0d", c, sbif.pending_count, ep[c]);
            end
        end
    endtask

    task automatic test_load_stall();
        int e5 [7] = '{1, 1, 1, 2, 2, 3, 0};
        for (int c = 0; c < 7; c++) begin
            case (c)
                0:       drive(1, 5, 1, 1, 0, 1, 0, 1, 0, 0);
                1:       drive(0, 0, 0, 1, 0, 1, 0, 1, 0, 0);
                2:       drive(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
                3:       drive(0, 0, 0, 1, 0, 0, 0, 0, 0, 1);
                4:       drive(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
                default: drive(0, 0, 0, 1, 0, 1, 0, 1, 0, 0);
            endcase
            tick();
            n_checks++;
            if (sbif.register_invalid[5] !== 3'(e5[c])) begin
                n_fail++;
                $display("FAIL load_stall c%0d r5 got %0d expected %0d", c, sbif.register_invalid[5], e5[c]);
            end
            n_checks++;
            if (sbif.pending_count !== 2'(m_pending)) begin
                n_fail++;
                $display("FAIL load_stall c%0d pending got %0d expected %0d", c, sbif.pending_count, m_pending);
            end
        end
    endtask

    task automatic test_back_to_back();
        drive(1, 2, 0, 1, 0, 1, 0, 1, 0, 0);
        tick();
        drive(1, 2, 1, 1, 0, 1, 0, 1, 0, 0);
        tick();
        n_checks++;
        if (sbif.register_invalid[2] !== 3'd1) begin
            n_fail++;
            $display("FAIL back_to_back r2 got %0d expected 1", sbif.register_invalid[2]);
        end
        for (int c = 0; c < 4; c++) begin
            drive(0, 0, 0, 1, 0, 1, 0, 1, 0, c == 1);
            tick();
            for (int r = 0; r < NREG; r++) begin
                n_checks++;
                if (sbif.register_invalid[r] !== 3'(exp_code(r))) begin
                    n_fail++;
                    $display("FAIL back_to_back c%0d r%0d got %0d expected %0d", c, r, sbif.register_invalid[r], exp_code(r));
                end
            end
        end
    endtask

    task automatic test_flush_idex();
        drive(1, 4, 0, 1, 1, 1, 0, 1, 0, 0);
        tick();
        n_checks++;
        if (sbif.register_invalid[4] !== 3'd0) begin
            n_fail++;
            $display("FAIL flush_idex r4 got %0d expected 0", sbif.register_invalid[4]);
        end
        n_checks++;
        if (sbif.pending_count !== 2'(m_pending)) begin
            n_fail++;
            $display("FAIL flush_idex pending got %0d expected %0d", sbif.pending_count, m_pending);
        end
    endtask

    task automatic test_jump_miss();
        int rds [3] = '{1, 6, 7};
        for (int c = 0; c < 3; c++) begin
            drive(1, rds[c], 0, 1, 0, 1, 0, 1, 0, 0);
            tick();
        end
        n_checks++;
        if (sbif.pending_count !== 2'd3) begin
            n_fail++;
            $display("FAIL jump_miss fill pending got %0d expected 3", sbif.pending_count);
        end
        for (int c = 0; c < 2; c++) begin
            drive(0, 0, 0, 1, c == 0, 1, c == 0, 1, 0, 0);
            tick();
            for (int r = 0; r < NREG; r++) begin
                int want;
                want = (c == 0 && r == 6) ? 3 : 0;
                n_checks++;
                if (sbif.register_invalid[r] !== 3'(want)) begin
                    n_fail++;
                    $display("FAIL jump_miss c%0d r%0d got %0d expected %0d", c, r, sbif.register_invalid[r], want);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        drive(1, 1, 0, 1, 0, 1, 0, 1, 0, 0);
        tick();
        drive(1, 2, 1, 1, 0, 1, 0, 1, 0, 0);
        tick();
        drive(1, 3, 0, 1, 0, 0, 0, 0, 0, 0);
        tick();
        reset_n = 1'b0;
        drive(1, 5, 1, 1, 0, 1, 0, 1, 0, 1);
        tick();
        reset_n = 1'b1;
        drive(0, 0, 0, 1, 0, 1, 0, 1, 0, 0);
        for (int r = 0; r < NREG; r++) begin
            n_checks++;
            if (sbif.register_invalid[r] !== 3'd0) begin
                n_fail++;
                $display("FAIL reset_mid r%0d got %0d expected 0", r, sbif.register_invalid[r]);
            end
        end
        n_checks++;
        if (sbif.pending_count !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_mid pending got %0d expected 0", sbif.pending_count);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 500; c++) begin
            reset_n = ($urandom_range(0, 59) != 0);
            drive($urandom_range(0, 3) != 0, $urandom_range(0, NREG - 1), $urandom_range(0, 2) == 0,
                  $urandom_range(0, 4) != 0, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 11) == 0,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 11) == 0,
                  $urandom_range(0, 2) == 0);
            tick();
            for (int r = 0; r < NREG; r++) begin
                n_checks++;
                if (sbif.register_invalid[r] !== 3'(exp_code(r))) begin
                    n_fail++;
                    $display("FAIL random c%0d r%0d got %0d expected %0d", c, r, sbif.register_invalid[r], exp_code(r));
                end
            end
            n_checks++;
            if (sbif.pending_count !== 2'(m_pending)) begin
                n_fail++;
                $display("FAIL random c%0d pending got %0d expected %0d", c, sbif.pending_count, m_pending);
            end
        end
        reset_n = 1'b1;
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        m_pending = 0;
        pipe      = '{'{0, 0, 0, 0}, '{0, 0, 0, 0}, '{0, 0, 0, 0}};
        test_reset();
        test_alu_flow();
        test_load_stall();
        test_back_to_back();
        test_flush_idex();
        test_jump_miss();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
